// File: rtl/conv_tap_mac.sv
// conv_tap_mac
// Convolution tap sequencer and accumulator. One m*m pixel window is
// accepted per handshake. The block then walks the kernel store address
// through taps 0..m*m-1, one tap per cycle, and adds every latched pixel
// whose kernel weight bit is 1. The window sum is then offered on a
// valid/ready output channel.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : a window is present on in_window
//   in_ready  : block can accept a window (IDLE only)
//   in_window : m*m pixels, tap i at in_window[i*DW +: DW]
//   k_addr    : tap address to the kernel store (0 outside RUN)
//   k_bit     : weight bit at k_addr, combinational from the store
//   out_valid : out_sum holds a finished window sum (DONE)
//   out_ready : consumer accepts out_sum
//   out_sum   : unsigned sum of the pixels whose weight bit is 1
//   busy      : high in RUN or DONE
module conv_tap_mac #(
  parameter int m  = 3,
  parameter int DW = 8,
  parameter int SW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [m*m*DW-1:0]   in_window,
  output logic [6:0]          k_addr,
  input  logic                k_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW-1:0]       out_sum,
  output logic                busy
);

  localparam int NT = m * m;
  localparam logic [6:0] LAST_TAP = 7'(NT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NT*DW-1:0]    win_q, win_d;
  logic [SW-1:0]       acc_q, acc_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [6:0]          tap_q, tap_d;

  logic [DW-1:0]       pixel;
  logic [SW-1:0]       addend;

  // Select the latched pixel for the current tap. A compare-and-pick loop
  // keeps the index in range even if the tap counter were ever corrupted.
  always_comb begin
    pixel = '0;
    for (int i = 0; i < NT; i++) begin
      if (tap_q == 7'(i)) begin
        pixel = win_q[i*DW +: DW];
      end
    end
    addend = k_bit ? {{(SW-DW){1'b0}}, pixel} : '0;
  end

  // Next-state logic. Every register holds by default. In RUN the final
  // tap writes its contribution straight into the output sum register, so
  // out_sum is already complete on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    tap_d   = tap_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d   = in_window;
          acc_d   = '0;
          tap_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + addend;
        tap_d = tap_q + 7'd1;
        if (tap_q == LAST_TAP) begin
          sum_d   = acc_q + addend;
          tap_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state. The store address is forced to 0
  // outside RUN so that it never leaves the 0..m*m-1 range.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN) || (state_q == DONE);
    out_valid = (state_q == DONE);
    k_addr    = (state_q == RUN) ? tap_q : 7'd0;
    out_sum   = sum_q;
  end

  // State registers. Reset clears everything, which discards any partial
  // sum, so no out_valid follows a reset taken in the middle of a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      tap_q   <= tap_d;
    end
  end

endmodule

// File: tb/tb_conv_tap_mac.sv
// tb_conv_tap_mac
// Self-checking bench for conv_tap_mac. A behavioural model tracks the
// transaction timeline: a window is accepted, m*m tap cycles follow, then
// the result is offered until it is handshaked. On every negative edge,
// one compare process checks all outputs against that model. Directed
// windows with hand-computed sums pin the model. A randomized run follows.
module tb_conv_tap_mac;

  localparam int M  = 3;
  localparam int DW = 8;
  localparam int SW = 12;
  localparam int NT = M * M;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [NT*DW-1:0]    in_window;
  logic [6:0]          k_addr;
  logic                k_bit;
  logic                out_valid;
  logic                out_ready;
  logic [SW-1:0]       out_sum;
  logic                busy;

  logic [NT-1:0]       kernel;
  logic [127:0]        kernel_ext;

  int tests_run    = 0;
  int tests_failed = 0;

  conv_tap_mac #(.m(M), .DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .k_addr    (k_addr),
    .k_bit     (k_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  // The kernel store is combinational: the weight bit follows the address
  // in the same cycle.
  assign kernel_ext = {{(128-NT){1'b0}}, kernel};
  assign k_bit      = kernel_ext[k_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Plain arithmetic window sum: add every pixel whose weight bit is set.
  function automatic int sumWindow(input logic [NT*DW-1:0] w, input logic [NT-1:0] k);
    int s;
    s = 0;
    for (int i = 0; i < NT; i++) begin
      if (k[i]) s += int'(w[i*DW +: DW]);
    end
    return s;
  endfunction

  function automatic logic [NT*DW-1:0] seqWindow();
    logic [NT*DW-1:0] w;
    for (int i = 0; i < NT; i++) w[i*DW +: DW] = DW'(i + 1);
    return w;
  endfunction

  function automatic logic [NT*DW-1:0] constWindow(input int v);
    logic [NT*DW-1:0] w;
    for (int i = 0; i < NT; i++) w[i*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic logic [NT*DW-1:0] randWindow();
    logic [NT*DW-1:0] w;
    for (int i = 0; i < NT; i++) w[i*DW +: DW] = DW'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural timeline model. phase 0 is waiting for a window,
  // phases 1..NT are the tap cycles (tap = phase-1), and phase NT+1 holds
  // the result. The expected sum is computed in one step at acceptance.
  int mphase  = 0;
  int pending = 0;
  int exp_sum = 0;
  int cyc     = 0;
  int accepts[$];
  bit checking_on = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mphase  <= 0;
      exp_sum <= 0;
    end else if (mphase == 0) begin
      if (in_valid) begin
        mphase  <= 1;
        pending <= sumWindow(in_window, kernel);
        accepts.push_back(cyc);
      end
    end else if (mphase < NT) begin
      mphase <= mphase + 1;
    end else if (mphase == NT) begin
      mphase  <= NT + 1;
      exp_sum <= pending;
    end else if (out_ready) begin
      mphase <= 0;
    end
  end

  // Compare every output against the model on each cycle after the first
  // reset.
  always @(negedge clk) begin
    if (checking_on) begin
      checkOutput("cyc_in_ready",  int'(in_ready),  (mphase == 0) ? 1 : 0);
      checkOutput("cyc_busy",      int'(busy),      (mphase != 0) ? 1 : 0);
      checkOutput("cyc_out_valid", int'(out_valid), (mphase == NT + 1) ? 1 : 0);
      checkOutput("cyc_k_addr",    int'(k_addr),
                  (mphase >= 1 && mphase <= NT) ? mphase - 1 : 0);
      checkOutput("cyc_out_sum",   int'(out_sum),   exp_sum);
    end
  end

  // Record the tap addresses presented while running, for the literal
  // address-sequence check.
  int ktrace[$];
  always @(negedge clk) begin
    if (busy === 1'b1 && out_valid === 1'b0) ktrace.push_back(int'(k_addr));
  end

  // Present one window and wait for its result. hold > 0 keeps out_ready
  // low for that many cycles of DONE while offering an extra window that
  // must be ignored. keep leaves in_valid high for back-to-back use.
  task automatic applyStimulus(input logic [NT*DW-1:0] win, input logic [NT-1:0] kern,
                               input int hold, input bit keep, input int expected,
                               input string name);
    bit ok;
    @(negedge clk);
    in_window = win;
    kernel    = kern;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput({name, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = keep;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput({name, "_result_timeout"}, 0, 1);
      out_ready = 1'b1;
      return;
    end
    checkOutput({name, "_sum"}, int'(out_sum), expected);
    if (hold > 0) begin
      in_valid  = 1'b1;
      in_window = ~win;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checkOutput({name, "_hold_valid"}, int'(out_valid), 1);
        checkOutput({name, "_hold_sum"},   int'(out_sum),   expected);
        checkOutput({name, "_hold_ready"}, int'(in_ready),  0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput({name, "_ready_after_hs"}, int'(in_ready),  1);
      checkOutput({name, "_valid_after_hs"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int mark;
    logic [NT*DW-1:0] w;
    logic [NT-1:0]    k;
    bit ok;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_window = '0;
    kernel    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking_on = 1'b1;

    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_sum",   int'(out_sum),   0);
    checkOutput("rst_k_addr",    int'(k_addr),    0);
    checkOutput("rst_busy",      int'(busy),      0);

    // All-ones kernel over pixels 1..9, with the tap address sequence.
    ktrace.delete();
    applyStimulus(seqWindow(), 9'h1FF, 0, 1'b0, 45, "ones_seq");
    checkOutput("ktrace_len", ktrace.size(), NT);
    for (int i = 0; i < NT && i < ktrace.size(); i++) begin
      checkOutput("ktrace_addr", ktrace[i], i);
    end

    applyStimulus(seqWindow(), 9'h155, 0, 1'b0, 25, "even_taps");
    applyStimulus(seqWindow(), 9'h000, 0, 1'b0, 0, "zero_kernel");
    applyStimulus(constWindow(255), 9'h1FF, 0, 1'b0, 2295, "max_sum");

    // Consumer stalls five cycles in DONE.
    applyStimulus(seqWindow(), 9'h1FF, 5, 1'b0, 45, "stall");

    // Reset taken at tap 4 discards the partial sum.
    @(negedge clk);
    in_window = seqWindow();
    kernel    = 9'h1FF;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (k_addr == 7'd4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach_tap4", int'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready",  int'(in_ready),  1);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_out_sum",   int'(out_sum),   0);
    checkOutput("midrst_k_addr",    int'(k_addr),    0);
    repeat (12) @(negedge clk);
    checkOutput("midrst_no_valid", int'(out_valid), 0);
    applyStimulus(constWindow(2), 9'h1FF, 0, 1'b0, 18, "after_rst");

    // Back-to-back windows with in_valid held high.
    mark = accepts.size();
    for (int n = 0; n < 4; n++) begin
      w = randWindow();
      k = NT'($urandom_range(0, 511));
      applyStimulus(w, k, 0, 1'b1, sumWindow(w, k), "b2b");
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", accepts.size() - mark, 4);
    for (int n = 0; n < 3 && mark + n + 1 < accepts.size(); n++) begin
      checkOutput("b2b_spacing", accepts[mark+n+1] - accepts[mark+n], NT + 2);
    end

    // Randomized windows, kernels and consumer stalls.
    for (int n = 0; n < 20; n++) begin
      w = randWindow();
      k = NT'($urandom_range(0, 511));
      applyStimulus(w, k, $urandom_range(0, 3), 1'b0, sumWindow(w, k), "rand");
    end

    repeat (3) @(negedge clk);
    checking_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conv_tap_mac.md
Name: conv_tap_mac

Overview:
- Convolution tap sequencer/accumulator, directly downstream of the binary kernel address-generator store.
- Accepts one m×m pixel window per handshake and steps the 7-bit kernel address through taps 0..m*m-1.
- Reads back one binary weight bit per cycle and accumulates the pixels whose weight bit is 1.
- Emits one window sum per window on a valid/ready output channel toward the activation/pooling stage.

Parameters:
- m, 3: kernel/window side length; m*m ≤ 128, so every tap is reachable with the 7-bit address.
- DW, 8: pixel width, unsigned.
- SW, 12: sum width; must satisfy SW ≥ DW + ceil(log2(m*m)). Default covers 9×255 = 2295.

Ports:
- clk, input, 1: single clock; everything is updated on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: window present on in_window.
- in_ready, output, 1: block can accept a window.
- in_window, input, m*m*DW: pixel for tap i is in_window[i*DW +: DW].
- k_addr, output, 7: tap address driven to the kernel store.
- k_bit, input, 1: kernel weight bit at k_addr, combinational from the store and valid in the same cycle.
- out_valid, output, 1: out_sum is valid.
- out_ready, input, 1: consumer accepts out_sum.
- out_sum, output, SW: unsigned sum of pixels with weight bit 1.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, k_addr=0, busy=0, accumulator=0, tap counter=0, window register=0.
- IDLE:
  - in_ready=1, k_addr=0.
  - On in_valid && in_ready: latch in_window into the internal register, clear the accumulator and tap counter, go to RUN.
  - in_valid without in_ready is ignored.
- RUN:
  - in_ready=0, busy=1, k_addr = tap counter (zero-extended to 7 bits).
  - Each cycle: if k_bit==1, add the latched pixel[tap] (zero-extended) to the accumulator; otherwise hold the accumulator.
  - Tap counter increments each cycle. On the edge that processes tap m*m-1, write the final sum to out_sum, set out_valid=1, go to DONE.
  - RUN lasts exactly m*m cycles.
  - k_bit is sampled on the same edge that k_addr is presented; there is no registered read.
- DONE:
  - out_valid=1. out_sum is stable and k_addr=0.
  - On out_ready: next edge clears out_valid, goes to IDLE, and in_ready rises.
  - While out_ready=0, all outputs hold indefinitely.
- Latency: window accepted on edge E; taps are presented on cycles E+1..E+m*m; out_valid rises after edge E+m*m. Minimum throughput is one window per m*m+2 cycles.
- Arithmetic: unsigned, no saturation. Width is guaranteed by the SW constraint, so overflow is impossible.
- in_window changes after acceptance do not affect the result, because it is latched.
- k_bit changes mid-RUN are used as-is. The upstream store is responsible for holding the kernel stable during a window.
- Reset mid-operation: rst in any state returns all outputs to their reset values on that edge and discards the partial sum; no out_valid follows.
- Simultaneous rst with in_valid or out_ready: rst wins.
- k_addr never exceeds m*m-1.

Test Plan:
- Kernel all ones, pixels 1..9, out_ready=1 → k_addr sequence 0,1,…,8 on consecutive cycles; out_valid one cycle after tap 8; out_sum=45.
- Kernel bits 0,2,4,6,8 set (0x155), pixels 1..9 → out_sum=25. Kernel all zeros → out_sum=0.
- All pixels 255, kernel all ones → out_sum=2295 with no truncation.
- out_ready held low 5 cycles in DONE → out_valid, out_sum=45 and in_ready=0 all held; the next window is accepted only after the out_ready handshake, and a new in_valid during DONE is ignored.
- rst asserted at tap 4 of RUN → next edge: in_ready=1, out_valid=0, out_sum=0, k_addr=0. A fresh window (pixels all 2, kernel all ones) then yields 18.
- Back-to-back windows with in_valid held high and out_ready=1 → each result correct; accepts are spaced m*m+2 = 11 cycles apart.
